// File: rtl/mac_pkg.sv
// Shared MAC lane types: element geometry, IFM beat payload, IFM sequencer state/command.
package mac_pkg;

  localparam int unsigned MAC_W_ELEMENT = 16;
  localparam int unsigned MAC_N_ELEMENT = 64;
  localparam int unsigned MAC_W_CNT     = 16;

  typedef enum logic [0:0] {
    IFM_SEQ_IDLE = 1'b0,
    IFM_SEQ_RUN  = 1'b1
  } mac_ifm_seq_state;

  typedef struct packed {
    logic [MAC_W_CNT-1:0] inter_len;
    logic [MAC_W_CNT-1:0] accum_len;
    logic [MAC_W_CNT-1:0] group_cnt;
    logic [5:0]           last_elems;
  } mac_ifm_seq_cmd;

  typedef struct packed {
    logic [MAC_W_ELEMENT*MAC_N_ELEMENT-1:0] data;
    logic [MAC_N_ELEMENT-1:0]               data_element_valid;
    logic                                   inter_end;
    logic                                   accum_end;
  } mac_lane_ifm_port;

endpackage

// File: rtl/mac_ifm_mask_gen.sv
// Per-element valid mask: all ones, or elements [last_elems:0] only on the last beat of a segment.
module mac_ifm_mask_gen
  import mac_pkg::*;
(
  input  logic [5:0]               last_elems,
  input  logic                     is_last,
  output logic [MAC_N_ELEMENT-1:0] mask
);

  always_comb begin
    mask = '1;
    if (is_last) begin
      for (int unsigned i = 0; i < MAC_N_ELEMENT; i++) begin
        mask[i] = (i <= 32'(last_elems));
      end
    end
  end

endmodule

// File: rtl/mac_ifm_sequencer.sv
// MAC lane IFM port driver: expands a loop command over a source word stream into tagged beats.
// Optional MAC_IFM_SEQ_ZERO_PAD_EN zeroes element fields outside the valid mask.
module mac_ifm_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned W_CNT = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_cmd_valid,
  output logic                                   o_cmd_ready,
  input  logic [W_CNT-1:0]                       i_cmd_inter_len,
  input  logic [W_CNT-1:0]                       i_cmd_accum_len,
  input  logic [W_CNT-1:0]                       i_cmd_group_cnt,
  input  logic [5:0]                             i_cmd_last_elems,
  input  logic                                   i_src_valid,
  output logic                                   o_src_ready,
  input  logic [MAC_W_ELEMENT*MAC_N_ELEMENT-1:0] i_src_data,
  output logic                                   o_ifm_valid,
  input  logic                                   i_ifm_ready,
  output mac_lane_ifm_port                       o_ifm,
  output logic                                   o_busy,
  output logic                                   o_done
);

  mac_ifm_seq_state state_q;

  logic [W_CNT-1:0] inter_len_q;
  logic [W_CNT-1:0] accum_len_q;
  logic [W_CNT-1:0] group_len_q;
  logic [5:0]       last_elems_q;

  logic [W_CNT-1:0] beat_cnt_q;
  logic [W_CNT-1:0] inter_cnt_q;
  logic [W_CNT-1:0] group_cnt_q;

  mac_lane_ifm_port ifm_q;
  logic             ifm_valid_q;
  logic             final_q;
  logic             done_q;

  logic run;
  logic src_ready;
  logic src_hs;
  logic out_hs;
  logic beat_last;
  logic inter_last;
  logic beat_final;

  logic [MAC_N_ELEMENT-1:0]               mask;
  logic [MAC_W_ELEMENT*MAC_N_ELEMENT-1:0] data_d;

  assign run        = (state_q == IFM_SEQ_RUN);
  assign src_ready  = run && (!ifm_valid_q || i_ifm_ready);
  assign src_hs     = src_ready && i_src_valid;
  assign out_hs     = ifm_valid_q && i_ifm_ready;
  assign beat_last  = (beat_cnt_q == inter_len_q);
  assign inter_last = beat_last && (inter_cnt_q == accum_len_q);
  assign beat_final = inter_last && (group_cnt_q == group_len_q);

  mac_ifm_mask_gen u_mask_gen (
    .last_elems (last_elems_q),
    .is_last    (beat_last),
    .mask       (mask)
  );

`ifdef MAC_IFM_SEQ_ZERO_PAD_EN
  always_comb begin
    data_d = '0;
    for (int unsigned e = 0; e < MAC_N_ELEMENT; e++) begin
      if (mask[e]) data_d[e*MAC_W_ELEMENT +: MAC_W_ELEMENT] = i_src_data[e*MAC_W_ELEMENT +: MAC_W_ELEMENT];
    end
  end
`else
  assign data_d = i_src_data;
`endif

  // Odometer: beat wraps into inter, inter wraps into group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IFM_SEQ_IDLE;
      inter_len_q  <= '0;
      accum_len_q  <= '0;
      group_len_q  <= '0;
      last_elems_q <= '0;
      beat_cnt_q   <= '0;
      inter_cnt_q  <= '0;
      group_cnt_q  <= '0;
    end else if (state_q == IFM_SEQ_IDLE) begin
      if (i_cmd_valid) begin
        state_q      <= IFM_SEQ_RUN;
        inter_len_q  <= i_cmd_inter_len;
        accum_len_q  <= i_cmd_accum_len;
        group_len_q  <= i_cmd_group_cnt;
        last_elems_q <= i_cmd_last_elems;
        beat_cnt_q   <= '0;
        inter_cnt_q  <= '0;
        group_cnt_q  <= '0;
      end
    end else if (src_hs) begin
      if (beat_last) begin
        beat_cnt_q <= '0;
        if (inter_last) begin
          inter_cnt_q <= '0;
          group_cnt_q <= group_cnt_q + 1'b1;
        end else begin
          inter_cnt_q <= inter_cnt_q + 1'b1;
        end
      end else begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (beat_final) state_q <= IFM_SEQ_IDLE;
    end
  end

  // The final tag rides with the beat so done tracks the downstream handoff, not the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_q       <= '0;
      ifm_valid_q <= 1'b0;
      final_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= out_hs && final_q;
      if (src_hs) begin
        ifm_q.data               <= data_d;
        ifm_q.data_element_valid <= mask;
        ifm_q.inter_end          <= beat_last;
        ifm_q.accum_end          <= inter_last;
        ifm_valid_q              <= 1'b1;
        final_q                  <= beat_final;
      end else if (out_hs) begin
        ifm_valid_q <= 1'b0;
        final_q     <= 1'b0;
      end
    end
  end

  assign o_cmd_ready = (state_q == IFM_SEQ_IDLE);
  assign o_src_ready = src_ready;
  assign o_ifm_valid = ifm_valid_q;
  assign o_ifm       = ifm_q;
  assign o_busy      = run || (ifm_valid_q && final_q);
  assign o_done      = done_q;

endmodule

// File: tb/tb_mac_ifm_sequencer.sv
// Directed self-checking bench for mac_ifm_sequencer (beat tagging, stalls, reset, back-to-back commands).
module tb_mac_ifm_sequencer;
  import mac_pkg::*;

  localparam int unsigned WD = MAC_W_ELEMENT * MAC_N_ELEMENT;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [15:0]      i_cmd_inter_len;
  logic [15:0]      i_cmd_accum_len;
  logic [15:0]      i_cmd_group_cnt;
  logic [5:0]       i_cmd_last_elems;
  logic             i_src_valid;
  logic             o_src_ready;
  logic [WD-1:0]    i_src_data;
  logic             o_ifm_valid;
  logic             i_ifm_ready;
  mac_lane_ifm_port o_ifm;
  logic             o_busy;
  logic             o_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_ifm_sequencer #(.W_CNT(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_inter_len  (i_cmd_inter_len),
    .i_cmd_accum_len  (i_cmd_accum_len),
    .i_cmd_group_cnt  (i_cmd_group_cnt),
    .i_cmd_last_elems (i_cmd_last_elems),
    .i_src_valid      (i_src_valid),
    .o_src_ready      (o_src_ready),
    .i_src_data       (i_src_data),
    .o_ifm_valid      (o_ifm_valid),
    .i_ifm_ready      (i_ifm_ready),
    .o_ifm            (o_ifm),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source word k: element e = {k, e}; dm=1 gives 0x3FF in every element.
  function automatic logic [WD-1:0] src_word(input int k, input int dm);
    logic [WD-1:0] w;
    for (int e = 0; e < 64; e++) begin
      w[e*16 +: 16] = (dm != 0) ? 16'h03FF : 16'((k << 6) | e);
    end
    return w;
  endfunction

  function automatic logic [63:0] tail_mask(input int le);
    logic [63:0] m;
    for (int e = 0; e < 64; e++) m[e] = (e <= le);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input int il, input int al, input int gl, input int le);
    i_cmd_valid      = 1'b1;
    i_cmd_inter_len  = 16'(il);
    i_cmd_accum_len  = 16'(al);
    i_cmd_group_cnt  = 16'(gl);
    i_cmd_last_elems = 6'(le);
    tick();
    i_cmd_valid = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic run_cmd(input string nm, input int il, input int al, input int gl, input int le,
                         input int mode, input int dm);
    int n, sidx, bidx, cyc, post, bis, seg, bad;
    logic stall, final_handed, done_next, ie, ae;
    logic [63:0] emask;
    logic [WD-1:0] sw;
    logic [15:0] ge, xe;
    mac_lane_ifm_port saved;
    n = (il + 1) * (al + 1) * (gl + 1);
    sidx = 0; bidx = 0; cyc = 0; post = 0;
    stall = 1'b0; final_handed = 1'b0; done_next = 1'b0;
    saved = '0;
    check({nm, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    issue_cmd(il, al, gl, le);
    while (post < 3 && cyc < 400) begin
      i_ifm_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      i_src_valid = (sidx < n);
      i_src_data  = src_word(sidx, dm);
      @(negedge clk);
      if (stall) begin
        check({nm, "_stable"}, 64'(o_ifm === saved), 64'd1);
        check({nm, "_stall_valid"}, 64'(o_ifm_valid), 64'd1);
      end
      if (o_ifm_valid && !i_ifm_ready) check({nm, "_bp_src_ready"}, 64'(o_src_ready), 64'd0);
      check({nm, "_done"}, 64'(o_done), 64'(done_next));
      check({nm, "_busy"}, 64'(o_busy), 64'(!final_handed));
      done_next = 1'b0;
      if (o_ifm_valid && i_ifm_ready) begin
        bis   = bidx % (il + 1);
        seg   = (bidx / (il + 1)) % (al + 1);
        ie    = (bis == il);
        ae    = ie && (seg == al);
        emask = ie ? tail_mask(le) : '1;
        check({nm, "_inter_end"}, 64'(o_ifm.inter_end), 64'(ie));
        check({nm, "_accum_end"}, 64'(o_ifm.accum_end), 64'(ae));
        check({nm, "_mask"}, o_ifm.data_element_valid, emask);
        sw  = src_word(bidx, dm);
        bad = 0;
        for (int e = 63; e >= 0; e--) begin
          xe = sw[e*16 +: 16];
`ifdef MAC_IFM_SEQ_ZERO_PAD_EN
          if (!emask[e]) xe = 16'h0;
`endif
          if (o_ifm.data[e*16 +: 16] !== xe) bad = e;
        end
        ge = o_ifm.data[bad*16 +: 16];
        xe = sw[bad*16 +: 16];
`ifdef MAC_IFM_SEQ_ZERO_PAD_EN
        if (!emask[bad]) xe = 16'h0;
`endif
        check({nm, "_data"}, 64'(ge), 64'(xe));
        if (bidx == n - 1) begin
          done_next    = 1'b1;
          final_handed = 1'b1;
        end
        bidx++;
      end
      stall = o_ifm_valid && !i_ifm_ready;
      saved = o_ifm;
      if (o_src_ready && i_src_valid) sidx++;
      if (final_handed) post++;
      tick();
      cyc++;
    end
    i_src_valid = 1'b0;
    check({nm, "_beats"}, 64'(bidx), 64'(n));
    check({nm, "_src_words"}, 64'(sidx), 64'(n));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    check({nm, "_src_ready"}, 64'(o_src_ready), 64'd0);
    check({nm, "_ifm_valid"}, 64'(o_ifm_valid), 64'd0);
    check({nm, "_ifm_zero"}, 64'(o_ifm === '0), 64'd1);
    check({nm, "_busy"}, 64'(o_busy), 64'd0);
    check({nm, "_done"}, 64'(o_done), 64'd0);
  endtask

  logic [WD-1:0] w_tmp;
  logic [WD-1:0] w_dut;

  initial begin
    int handed, cyc;
    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_inter_len = '0; i_cmd_accum_len = '0;
    i_cmd_group_cnt = '0; i_cmd_last_elems = '0;
    i_src_valid = 1'b0; i_src_data = '0; i_ifm_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_cmd("single", 0, 0, 0, 63, 0, 0);
    run_cmd("cont12", 2, 1, 1, 9, 0, 0);
    run_cmd("stall12", 2, 1, 1, 9, 1, 0);
    run_cmd("zpad", 0, 0, 3, 0, 0, 1);

    // Reset pulse after four beats of a 12-beat command.
    issue_cmd(2, 1, 1, 9);
    handed = 0; cyc = 0;
    i_ifm_ready = 1'b1;
    while (handed < 4 && cyc < 50) begin
      i_src_valid = 1'b1;
      i_src_data  = src_word(cyc, 0);
      @(negedge clk);
      if (o_ifm_valid && i_ifm_ready) handed++;
      tick();
      cyc++;
    end
    check("rstmid_beats", 64'(handed), 64'd4);
    i_src_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_done", 64'(o_done), 64'd0);
      check("rstmid_idle_busy", 64'(o_busy), 64'd0);
    end
    tick();
    run_cmd("after_rst", 2, 1, 1, 9, 0, 0);

    // Second command accepted while the first command's final beat stalls downstream.
    i_ifm_ready = 1'b0;
    i_src_valid = 1'b1;
    i_src_data  = src_word(100, 0);
    issue_cmd(0, 0, 0, 63);
    tick();
    @(negedge clk);
    check("b2b_pend_valid", 64'(o_ifm_valid), 64'd1);
    check("b2b_pend_busy", 64'(o_busy), 64'd1);
    check("b2b_pend_cmd_ready", 64'(o_cmd_ready), 64'd1);
    tick();
    i_src_data = src_word(101, 0);
    issue_cmd(0, 0, 0, 63);
    @(negedge clk);
    check("b2b_run_busy", 64'(o_busy), 64'd1);
    check("b2b_run_src_ready", 64'(o_src_ready), 64'd0);
    w_tmp = src_word(100, 0);
    w_dut = o_ifm.data;
    check("b2b_hold_data", w_dut[63:0], w_tmp[63:0]);
    tick();
    i_ifm_ready = 1'b1;
    tick();
    i_src_valid = 1'b0;
    @(negedge clk);
    check("b2b_done1", 64'(o_done), 64'd1);
    check("b2b_busy1", 64'(o_busy), 64'd1);
    check("b2b_valid2", 64'(o_ifm_valid), 64'd1);
    w_tmp = src_word(101, 0);
    w_dut = o_ifm.data;
    check("b2b_data2", w_dut[63:0], w_tmp[63:0]);
    tick();
    @(negedge clk);
    check("b2b_done2", 64'(o_done), 64'd1);
    check("b2b_busy2", 64'(o_busy), 64'd0);
    check("b2b_valid_clr", 64'(o_ifm_valid), 64'd0);
    tick();
    @(negedge clk);
    check("b2b_done_end", 64'(o_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
